// File: rtl/acondicionador_botones_pkg.sv
// Shared definitions for the button conditioner: FSM encoding, counter width,
// default timing parameters and a saturating increment helper.
package acondicionador_botones_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam int CNT_W = 26;

  localparam int DEB_CYCLES_DEF = 500000;
  localparam int REP_DELAY_DEF  = 50000000;
  localparam int REP_RATE_DEF   = 10000000;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/acondicionador_botones_antirrebote.sv
// One button channel: 2-flop synchronizer followed by a counting debouncer.
// The debounced level flips only after DEB_CYCLES consecutive differing samples.
module antirrebote
  import acondicionador_botones_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES);

  logic          meta;
  logic          sync;
  logic [DW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the synchronizer chain relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Up/down push-button conditioner: debounce, one pulse per press, lock-out on
// both buttons, and optional auto-repeat compiled in with ACONDICIONADOR_AUTOREPEAT_EN.
module acondicionador_botones
  import acondicionador_botones_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_RATE   = REP_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic EN
);

  if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_RATE < 1 ||
      REP_DELAY > 2**CNT_W || REP_RATE > 2**CNT_W) begin : g_bad_cfg
    $error("acondicionador_botones: timing parameter out of range");
  end

  logic   lvl_up;
  logic   lvl_down;
  state_t state, state_n;
  logic   ch, ch_n;          // active channel: 0 = up, 1 = down
  logic   up_n, down_n;
  logic   held;

`ifdef ACONDICIONADOR_AUTOREPEAT_EN
  localparam cnt_t DELAY_LAST = cnt_t'(REP_DELAY - 1);
  localparam cnt_t RATE_LAST  = cnt_t'(REP_RATE - 1);
  cnt_t cnt, cnt_n;
`endif

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (lvl_up)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .level (lvl_down)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch    <= 1'b0;
      up    <= 1'b0;
      down  <= 1'b0;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      ch    <= ch_n;
      up    <= up_n;
      down  <= down_n;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
      cnt   <= cnt_n;
`endif
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    up_n    = 1'b0;
    down_n  = 1'b0;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
    cnt_n   = cnt;
`endif
    held    = ch ? lvl_down : lvl_up;

    // Both buttons down overrides everything and suppresses pulses.
    if (lvl_up && lvl_down) begin
      state_n = LOCK;
    end else begin
      case (state)
        IDLE: begin
          if (lvl_up || lvl_down) begin
            state_n = DELAY;
            ch_n    = lvl_down;
            up_n    = lvl_up;
            down_n  = lvl_down;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
            cnt_n   = '0;
`endif
          end
        end
        DELAY: begin
          if (!held) begin
            state_n = IDLE;
          end
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
          else if (cnt == DELAY_LAST) begin
            state_n = REPEAT;
            up_n    = ~ch;
            down_n  = ch;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
`endif
        end
        REPEAT: begin
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
          if (!held) begin
            state_n = IDLE;
          end else if (cnt == RATE_LAST) begin
            up_n   = ~ch;
            down_n = ch;
            cnt_n  = '0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
`else
          state_n = IDLE;
`endif
        end
        LOCK: begin
          if (!lvl_up && !lvl_down) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign EN = up | down;

endmodule
